// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - shared types and constants for the game sequencer
// Purpose: FSM state enum, move-kind enum, field geometry and piece-id limits.
package game_sequencer_pkg;

  localparam int COLS    = 20;
  localparam int ROWS    = 20;
  localparam int SPAWN_X = 8;

  localparam int                 PIECE_W   = 3;
  localparam logic [PIECE_W-1:0] PIECE_MAX = 3'd6;

  typedef enum logic [2:0] {
    ST_SPAWN,
    ST_SPAWN_CHK,
    ST_PLAY,
    ST_MOVE_CHK,
    ST_LOCK,
    ST_CLEAR,
    ST_OVER
  } state_t;

  typedef enum logic [1:0] {
    MV_ROT,
    MV_LEFT,
    MV_RIGHT,
    MV_DOWN
  } move_t;

  // The random source can produce one id beyond the last real piece; fold it to 0.
  function automatic logic [PIECE_W-1:0] legal_piece(input logic [PIECE_W-1:0] r);
    return (r > PIECE_MAX) ? '0 : r;
  endfunction

endpackage

// File: rtl/game_sequencer_gravity_timer.sv
// rtl/game_sequencer_gravity_timer.sv - gravity tick counter for the game sequencer
// Purpose: counts 0..DIV-1 while enabled and pulses tick on the wrap cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable
//   clr      : synchronous clear (wins over en)
//   tick     : one-cycle pulse in the cycle the counter wraps
module gravity_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && !clr && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - active-piece controller for the playfield datapath
// Purpose: owns piece id/x/y/rotation, turns key pulses and gravity into candidate
// moves, runs the collision-check / lock / row-clear handshakes, keeps score.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   key_left/right/rot/drop        : one-cycle key pulses
//   random                         : piece source, sampled in SPAWN
//   chk_req, cand_*                : collision-check request and candidate
//   chk_ack, chk_collide           : check result
//   cur_*                          : committed piece state
//   lock_req / lock_done           : merge handshake
//   clr_req / clr_done, clr_lines  : row-clear handshake
//   score, score_flag, gameover    : status
module game_sequencer #(
  parameter int FALL_DIV = 25000000,
  parameter int SPAWN_X  = game_sequencer_pkg::SPAWN_X
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_rot,
  input  logic        key_drop,
  input  logic [2:0]  random,
  output logic        chk_req,
  output logic [2:0]  cand_piece,
  output logic [4:0]  cand_x,
  output logic [4:0]  cand_y,
  output logic [1:0]  cand_rot,
  input  logic        chk_ack,
  input  logic        chk_collide,
  output logic [2:0]  cur_piece,
  output logic [4:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic [1:0]  cur_rot,
  output logic        lock_req,
  input  logic        lock_done,
  output logic        clr_req,
  input  logic        clr_done,
  input  logic [2:0]  clr_lines,
  output logic [15:0] score,
  output logic        score_flag,
  output logic        gameover
);
  import game_sequencer_pkg::*;

  localparam logic [4:0] SPAWN_X5 = 5'(SPAWN_X);

  state_t state, next_state;
  move_t  move_kind, next_move;

  logic pend_rot, pend_left, pend_right, pend_drop, pend_fall;
  logic clr_rot, clr_left, clr_right, clr_drop, clr_fall;
  logic issue, commit, timer_clr, tick, live;
  logic [16:0] score_sum;

  gravity_timer #(.DIV(FALL_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   ((state == ST_PLAY) || (state == ST_MOVE_CHK)),
    .clr  (timer_clr),
    .tick (tick)
  );

  // Requests are pure state decodes: they rise with state entry and fall the
  // cycle after the ack moves the FSM on, so an ack outside the state is ignored.
  assign chk_req  = (state == ST_SPAWN_CHK) || (state == ST_MOVE_CHK);
  assign lock_req = (state == ST_LOCK);
  assign clr_req  = (state == ST_CLEAR);
  assign gameover = (state == ST_OVER);
  assign live     = (state != ST_OVER);

  assign score_sum = {1'b0, score} + {14'd0, clr_lines};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_SPAWN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    next_move  = move_kind;
    issue      = 1'b0;
    commit     = 1'b0;
    timer_clr  = 1'b0;
    clr_rot    = 1'b0;
    clr_left   = 1'b0;
    clr_right  = 1'b0;
    clr_drop   = 1'b0;
    clr_fall   = 1'b0;
    case (state)
      ST_SPAWN: next_state = ST_SPAWN_CHK;
      ST_SPAWN_CHK: begin
        if (chk_ack) begin
          if (chk_collide) begin
            next_state = ST_OVER;
          end else begin
            commit     = 1'b1;
            timer_clr  = 1'b1;
            next_state = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        // Edge moves are dropped without a check; a bottom-row fall locks directly.
        if (pend_rot) begin
          clr_rot    = 1'b1;
          issue      = 1'b1;
          next_move  = MV_ROT;
          next_state = ST_MOVE_CHK;
        end else if (pend_left) begin
          clr_left = 1'b1;
          if (cur_x != 5'd0) begin
            issue      = 1'b1;
            next_move  = MV_LEFT;
            next_state = ST_MOVE_CHK;
          end
        end else if (pend_right) begin
          clr_right = 1'b1;
          if (cur_x != 5'd31) begin
            issue      = 1'b1;
            next_move  = MV_RIGHT;
            next_state = ST_MOVE_CHK;
          end
        end else if (pend_drop || pend_fall) begin
          clr_drop = pend_drop;
          clr_fall = !pend_drop;
          if (cur_y == 5'd31) begin
            next_state = ST_LOCK;
          end else begin
            issue      = 1'b1;
            next_move  = MV_DOWN;
            next_state = ST_MOVE_CHK;
          end
        end
      end
      ST_MOVE_CHK: begin
        if (chk_ack) begin
          if (!chk_collide) begin
            commit     = 1'b1;
            next_state = ST_PLAY;
          end else if (move_kind == MV_DOWN) begin
            next_state = ST_LOCK;
          end else begin
            next_state = ST_PLAY;
          end
        end
      end
      ST_LOCK: begin
        clr_fall = 1'b1;
        if (lock_done) next_state = ST_CLEAR;
      end
      ST_CLEAR: if (clr_done) next_state = ST_SPAWN;
      ST_OVER:  next_state = ST_OVER;
      default:  next_state = ST_SPAWN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_piece <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      cand_rot   <= '0;
      cur_piece  <= '0;
      cur_x      <= SPAWN_X5;
      cur_y      <= '0;
      cur_rot    <= '0;
      move_kind  <= MV_ROT;
      pend_rot   <= 1'b0;
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
      pend_drop  <= 1'b0;
      pend_fall  <= 1'b0;
      score      <= '0;
      score_flag <= 1'b0;
    end else begin
      if (state == ST_SPAWN) begin
        cand_piece <= legal_piece(random);
        cand_x     <= SPAWN_X5;
        cand_y     <= '0;
        cand_rot   <= '0;
      end else if (issue) begin
        cand_piece <= cur_piece;
        cand_x     <= cur_x;
        cand_y     <= cur_y;
        cand_rot   <= cur_rot;
        move_kind  <= next_move;
        case (next_move)
          MV_ROT:   cand_rot <= cur_rot + 2'd1;
          MV_LEFT:  cand_x   <= cur_x - 5'd1;
          MV_RIGHT: cand_x   <= cur_x + 5'd1;
          default:  cand_y   <= cur_y + 5'd1;
        endcase
      end
      if (commit) begin
        cur_piece <= cand_piece;
        cur_x     <= cand_x;
        cur_y     <= cand_y;
        cur_rot   <= cand_rot;
      end
      // A fresh pulse wins over the clear of the same flag so it is never lost.
      pend_rot   <= (pend_rot   & ~clr_rot)   | (key_rot   & live);
      pend_left  <= (pend_left  & ~clr_left)  | (key_left  & live);
      pend_right <= (pend_right & ~clr_right) | (key_right & live);
      pend_drop  <= (pend_drop  & ~clr_drop)  | (key_drop  & live);
      pend_fall  <= (pend_fall  & ~clr_fall)  | tick;
      score_flag <= 1'b0;
      if ((state == ST_CLEAR) && clr_done) begin
        score      <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        score_flag <= (clr_lines != 3'd0);
      end
    end
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Central controller for the playfield datapath: piece position, piece choice, expansion, collision check, merge, and row clear.
- Owns the active-piece state (piece id, x, y, rotation) and generates the gravity tick.
- Turns key pulses and gravity into candidate moves, asks the collision checker about each one, and commits or discards it.
- Sequences lock/merge and row clear, then raises score and game-over status.
- Sits between the key-input debouncer and the field datapath; all field storage stays in the datapath.

Parameters:
FALL_DIV, 25000000, clk cycles per gravity tick (>=2)
SPAWN_X, 8, spawn column of piece origin
COLS, 20, field width in cells (field is COLS x ROWS = 400 bits)
ROWS, 20, field height in cells

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
key_left  in  1  one-cycle pulse, move left
key_right  in  1  one-cycle pulse, move right
key_rot  in  1  one-cycle pulse, rotate clockwise
key_drop  in  1  one-cycle pulse, soft drop (one row)
random  in  3  piece source, sampled in SPAWN
chk_req  out  1  collision-check request; held until chk_ack
cand_piece  out  3  candidate piece id
cand_x  out  5  candidate origin column
cand_y  out  5  candidate origin row
cand_rot  out  2  candidate rotation
chk_ack  in  1  check result valid, one cycle
chk_collide  in  1  1 = candidate overlaps background or leaves field; valid with chk_ack
cur_piece  out  3  committed piece id
cur_x  out  5  committed column
cur_y  out  5  committed row
cur_rot  out  2  committed rotation
lock_req  out  1  merge current piece into background; held until lock_done
lock_done  in  1  merge complete, one cycle
clr_req  out  1  start row-clear scan; held until clr_done
clr_done  in  1  clear complete, one cycle
clr_lines  in  3  rows removed (0..4); valid with clr_done
score  out  16  total cleared lines, saturating at 16'hFFFF
score_flag  out  1  one-cycle pulse when clr_lines>0
gameover  out  1  sticky game-over

Behaviour:
- Reset (async) values:
  - state=SPAWN; every output 0 except cur_x=SPAWN_X.
  - Pending flags, tick counter and score all cleared.
- States: SPAWN, SPAWN_CHK, PLAY, MOVE_CHK, LOCK, CLEAR, OVER.
- SPAWN (1 cycle):
  - piece = random, or 0 when random==7.
  - Candidate = (piece, SPAWN_X, 0, 0); go to SPAWN_CHK.
- SPAWN_CHK:
  - Assert chk_req and wait for chk_ack.
  - collide=1: go to OVER.
  - collide=0: commit candidate into cur_*, clear tick counter, go to PLAY.
- Tick counter:
  - Free-runs 0..FALL_DIV-1 in PLAY and MOVE_CHK only.
  - At wrap it sets pend_fall.
- Pending flags (pend_rot/left/right/drop/fall):
  - Each key pulse sets its flag in any state except OVER. Flags are sticky, so pulses are never lost while busy.
  - A flag clears when its move is issued.
  - Multiple pulses of one key while pending collapse to a single move.
- PLAY: choose one pending flag. Priority: rot > left > right > drop > fall.
  - rot: candidate rot = cur_rot+1 (mod 4).
  - left: candidate x = cur_x-1. If cur_x==0, the flag is discarded with no check.
  - right: candidate x = cur_x+1. If cur_x==31, the flag is discarded.
  - drop or fall: candidate y = cur_y+1. If cur_y==31, go straight to LOCK.
  - Go to MOVE_CHK.
  - No flag pending: stay in PLAY.
- MOVE_CHK: chk_req=1 until chk_ack.
  - collide=0: commit candidate.
  - collide=1 on a vertical move: go to LOCK.
  - collide=1 on rot/left/right: discard the move.
  - Otherwise return to PLAY.
- LOCK: lock_req=1 until lock_done; then go to CLEAR. pend_fall is cleared.
- CLEAR: clr_req=1 until clr_done.
  - score += clr_lines, saturating.
  - score_flag pulses in the cycle after clr_done when clr_lines>0.
  - Then go to SPAWN.
- OVER:
  - gameover=1 and stays set; all req outputs 0; key pulses ignored.
  - Exit only via rst.
- Handshake rules:
  - req outputs rise in the cycle after state entry.
  - cand_* stay stable while chk_req=1.
  - ack/done seen while the matching req=0 is ignored.
  - req drops in the cycle after ack.
- Minimum latency, key pulse to cur_* update: 3 cycles, given a 1-cycle ack (latch, issue, commit).
- Reset mid-handshake returns to SPAWN; the datapath must tolerate req dropping without ack.

Decomposition:
- Shared package holds:
  - state enum;
  - move-kind enum (ROT, LEFT, RIGHT, DOWN);
  - constants COLS, ROWS, SPAWN_X;
  - piece-id width 3 and PIECE_MAX=6.
- One sub-module, gravity_timer: counter with enable and clear inputs and a tick pulse output.

Test Plan:
- Spawn: reset, random=3, chk_collide=0 with 1-cycle ack -> cur_piece=3, cur_x=8, cur_y=0, cur_rot=0; state PLAY.
- Left boundary: cur_x=0, pulse key_left -> no chk_req within 5 cycles; cur_x remains 0.
- Simultaneous keys: key_rot and key_right in the same cycle, no collisions -> two checks, rot first; final cur_rot=1, cur_x=9.
- Landing: key_drop with chk_collide=1 -> lock_req, lock_done, clr_req; clr_lines=2 -> score=2, one score_flag pulse, new spawn.
- Game over: spawn check returns collide=1 -> gameover=1 sticky; further key pulses produce no chk_req; rst clears gameover and restarts spawn.
- Gravity: FALL_DIV=4, no keys -> a vertical chk_req every 4 PLAY cycles plus handshake; cur_y increments once per tick.
